// File: rtl/sdp_ram_if.sv
// Bus bundle for the simple dual-port RAM.
// The write port, read port and registered read data travel together.
interface sdp_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] wraddress;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic                  rden;
    logic [DATA_WIDTH-1:0] q;

    // Requester side: the buffer layer that owns the write and read pointers.
    modport master (
        output data, wraddress, wren, rdaddress, rden,
        input  q
    );

    // Storage side: the RAM itself.
    modport slave (
        input  data, wraddress, wren, rdaddress, rden,
        output q
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: one write port and one read port on a
// single clock, with a registered read output (one-cycle latency).
// Reset clears only the output register; stored words survive reset.
module sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic      clock,
    input  logic      reset,
    sdp_ram_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_reg;

    // Write port: no reset on the array so it maps onto block RAM and keeps
    // its contents across a reset pulse; writes still land while reset is high.
    always_ff @(posedge clock) begin
        if (bus.wren) begin
            mem[bus.wraddress] <= bus.data;
        end
    end

    // Read port: the non-blocking array read returns the pre-write word on a
    // same-address collision, giving old-data read-during-write behaviour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (bus.rden) begin
            q_reg <= mem[bus.rdaddress];
        end
    end

    assign bus.q = q_reg;
endmodule

// File: tb/tb_sdp_ram.sv
// Directed self-checking bench for sdp_ram.
// Inputs change 1 time unit after each rising edge; q is sampled there too.
module tb_sdp_ram;
    localparam int DW = 32;
    localparam int AW = 12;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    sdp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sdp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wren = 1'b0;
        bus.rden = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.data      = '0;
        bus.wraddress = '0;
        bus.rdaddress = '0;
        idle();
        tick();
        n_vec++;
        if (bus.q !== 32'h0) begin
            n_err++;
            $display("FAIL reset_q: got %h want %h", bus.q, 32'h0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_rw();
        bus.wren = 1'b1; bus.wraddress = 12'h005; bus.data = 32'hDEADBEEF;
        tick();
        idle();
        bus.rden = 1'b1; bus.rdaddress = 12'h005;
        tick();
        idle();
        n_vec++;
        if (bus.q !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL basic_rw: got %h want %h", bus.q, 32'hDEADBEEF);
        end
    endtask

    task automatic test_read_during_write();
        bus.wren = 1'b1; bus.wraddress = 12'h010; bus.data = 32'h1;
        tick();
        // Same edge: overwrite with 0x2 and read the same address.
        bus.wren = 1'b1; bus.wraddress = 12'h010; bus.data = 32'h2;
        bus.rden = 1'b1; bus.rdaddress = 12'h010;
        tick();
        bus.wren = 1'b0;
        n_vec++;
        if (bus.q !== 32'h1) begin
            n_err++;
            $display("FAIL rdw_old: got %h want %h", bus.q, 32'h1);
        end
        tick();
        idle();
        n_vec++;
        if (bus.q !== 32'h2) begin
            n_err++;
            $display("FAIL rdw_new: got %h want %h", bus.q, 32'h2);
        end
    endtask

    task automatic test_read_hold();
        bus.wren = 1'b1; bus.wraddress = 12'h020; bus.data = 32'h12345678;
        tick();
        bus.wren = 1'b0;
        bus.rden = 1'b1; bus.rdaddress = 12'h020;
        tick();
        bus.rden = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.rdaddress = 12'h005 + 12'(i);
            tick();
            n_vec++;
            if (bus.q !== 32'h12345678) begin
                n_err++;
                $display("FAIL read_hold[%0d]: got %h want %h", i, bus.q, 32'h12345678);
            end
        end
    endtask

    task automatic test_boundary();
        bus.wren = 1'b1; bus.wraddress = 12'hFFF; bus.data = 32'hA5A5A5A5;
        tick();
        bus.wraddress = 12'h000; bus.data = 32'h0000_0001;
        tick();
        bus.wren = 1'b0;
        bus.rden = 1'b1; bus.rdaddress = 12'hFFF;
        tick();
        n_vec++;
        if (bus.q !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL top_addr: got %h want %h", bus.q, 32'hA5A5A5A5);
        end
        bus.rdaddress = 12'h000;
        tick();
        idle();
        n_vec++;
        if (bus.q !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL bottom_addr: got %h want %h", bus.q, 32'h0000_0001);
        end
    endtask

    task automatic test_independent_ports();
        // Write 0x33 @0x031 while reading 0x030 (holding 0x22) on the same edge.
        bus.wren = 1'b1; bus.wraddress = 12'h030; bus.data = 32'h22;
        tick();
        bus.wraddress = 12'h031; bus.data = 32'h33;
        bus.rden = 1'b1; bus.rdaddress = 12'h030;
        tick();
        bus.wren = 1'b0;
        n_vec++;
        if (bus.q !== 32'h22) begin
            n_err++;
            $display("FAIL indep_rd: got %h want %h", bus.q, 32'h22);
        end
        bus.rdaddress = 12'h031;
        tick();
        idle();
        n_vec++;
        if (bus.q !== 32'h33) begin
            n_err++;
            $display("FAIL indep_wr: got %h want %h", bus.q, 32'h33);
        end
    endtask

    task automatic test_async_reset();
        // q currently 0x33 from the previous test; DEADBEEF lives at 0x005.
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.q !== 32'h0) begin
            n_err++;
            $display("FAIL async_clear: got %h want %h", bus.q, 32'h0);
        end
        // Write and attempted read while reset is held.
        bus.wren = 1'b1; bus.wraddress = 12'h040; bus.data = 32'hCAFEF00D;
        bus.rden = 1'b1; bus.rdaddress = 12'h005;
        tick();
        idle();
        n_vec++;
        if (bus.q !== 32'h0) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", bus.q, 32'h0);
        end
        reset = 1'b0;
        bus.rden = 1'b1; bus.rdaddress = 12'h005;
        tick();
        n_vec++;
        if (bus.q !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL preserved: got %h want %h", bus.q, 32'hDEADBEEF);
        end
        bus.rdaddress = 12'h040;
        tick();
        idle();
        n_vec++;
        if (bus.q !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL write_in_reset: got %h want %h", bus.q, 32'hCAFEF00D);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 4096; i++) begin
            bus.wren = 1'b1; bus.wraddress = 12'(i); bus.data = 32'(i);
            tick();
        end
        bus.wren = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            bus.rden = 1'b1; bus.rdaddress = 12'(i);
            tick();
            n_vec++;
            if (bus.q !== 32'(i)) begin
                n_err++;
                $display("FAIL ramp[%0d]: got %h want %h", i, bus.q, 32'(i));
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_read_during_write();
        test_read_hold();
        test_boundary();
        test_independent_ports();
        test_async_reset();
        test_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
